// File: rtl/sdram_rr_arbiter_if.sv
// Requester/controller bundle around sdram_rr_arbiter; the arbiter takes the slave modport.
// Handshake: req_valid[i] is held with stable addr/din/wmask until req_ready[i] pulses for one
// cycle; mem_valid is held with stable mem_* until mem_ready pulses for one cycle.
interface sdram_rr_arbiter_if #(
    parameter int NPORTS = 4,
    parameter int AW     = 25
);
    logic [NPORTS-1:0]    req_valid;
    logic [NPORTS*AW-1:0] req_addr;
    logic [NPORTS*32-1:0] req_din;
    logic [NPORTS*4-1:0]  req_wmask;
    logic [NPORTS-1:0]    req_ready;
    logic [31:0]          req_dout;
    logic                 mem_valid;
    logic [AW-1:0]        mem_addr;
    logic [31:0]          mem_din;
    logic [3:0]           mem_wmask;
    logic [31:0]          mem_dout;
    logic                 mem_ready;

    modport slave (
        input  req_valid, req_addr, req_din, req_wmask, mem_dout, mem_ready,
        output req_ready, req_dout, mem_valid, mem_addr, mem_din, mem_wmask
    );

    modport master (
        output req_valid, req_addr, req_din, req_wmask, mem_dout, mem_ready,
        input  req_ready, req_dout, mem_valid, mem_addr, mem_din, mem_wmask
    );
endinterface

// File: rtl/sdram_rr_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller port among NPORTS requesters.
// Define SDRAM_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module sdram_rr_arbiter #(
    parameter int NPORTS = 4,
    parameter int AW     = 25
) (
    input  logic                 clk,
    input  logic                 resetn,
    sdram_rr_arbiter_if.slave    bus,
    output logic [1:0]           dbg_state
);
    localparam int GW = (NPORTS > 2) ? $clog2(NPORTS) : 1;

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RELEASE = 2'd2} state_t;

    state_t            state_q, state_d;
    logic [GW-1:0]     grant_q, grant_d;
    logic [GW-1:0]     last_q, last_d;
    logic [GW-1:0]     win;
    logic              any_req;
    logic              mem_valid_q, mem_valid_d;
    logic [AW-1:0]     mem_addr_q, mem_addr_d;
    logic [31:0]       mem_din_q, mem_din_d;
    logic [3:0]        mem_wmask_q, mem_wmask_d;
    logic [NPORTS-1:0] req_ready_q, req_ready_d;
    logic [31:0]       req_dout_q, req_dout_d;
    logic [AW-1:0]     sel_addr;
    logic [31:0]       sel_din;
    logic [3:0]        sel_wmask;

    assign any_req = |bus.req_valid;

`ifdef SDRAM_ARB_FIXED_PRIO_EN
    always_comb begin
        win = '0;
        for (int i = NPORTS - 1; i >= 0; i--) begin
            if (bus.req_valid[i]) win = GW'(i);
        end
    end
`else
    // Scan starts just after the last served port, so it comes last in the next round.
    logic [GW-1:0] cand;
    logic          found;
    always_comb begin
        win   = '0;
        cand  = '0;
        found = 1'b0;
        for (int k = 1; k <= NPORTS; k++) begin
            cand = GW'((int'(last_q) + k) % NPORTS);
            if (!found && bus.req_valid[cand]) begin
                win   = cand;
                found = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        sel_addr  = '0;
        sel_din   = '0;
        sel_wmask = '0;
        for (int i = 0; i < NPORTS; i++) begin
            if (win == GW'(i)) begin
                sel_addr  = bus.req_addr[i*AW +: AW];
                sel_din   = bus.req_din[i*32 +: 32];
                sel_wmask = bus.req_wmask[i*4 +: 4];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            last_q      <= GW'(NPORTS - 1);
            mem_valid_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_din_q   <= '0;
            mem_wmask_q <= '0;
            req_ready_q <= '0;
            req_dout_q  <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            mem_valid_q <= mem_valid_d;
            mem_addr_q  <= mem_addr_d;
            mem_din_q   <= mem_din_d;
            mem_wmask_q <= mem_wmask_d;
            req_ready_q <= req_ready_d;
            req_dout_q  <= req_dout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = BUSY;
            BUSY:    if (bus.mem_ready) state_d = RELEASE;
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values for the registered outputs; RELEASE never arbitrates so valid can drop.
    always_comb begin
        grant_d     = grant_q;
        last_d      = last_q;
        mem_valid_d = mem_valid_q;
        mem_addr_d  = mem_addr_q;
        mem_din_d   = mem_din_q;
        mem_wmask_d = mem_wmask_q;
        req_ready_d = req_ready_q;
        req_dout_d  = req_dout_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_d     = win;
                    mem_valid_d = 1'b1;
                    mem_addr_d  = sel_addr;
                    mem_din_d   = sel_din;
                    mem_wmask_d = sel_wmask;
                end
            end
            BUSY: begin
                if (bus.mem_ready) begin
                    mem_valid_d = 1'b0;
                    req_dout_d  = bus.mem_dout;
                    last_d      = grant_q;
                    for (int i = 0; i < NPORTS; i++) begin
                        req_ready_d[i] = (grant_q == GW'(i));
                    end
                end
            end
            RELEASE: req_ready_d = '0;
            default: req_ready_d = '0;
        endcase
    end

    assign bus.mem_valid = mem_valid_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_din   = mem_din_q;
    assign bus.mem_wmask = mem_wmask_q;
    assign bus.req_ready = req_ready_q;
    assign bus.req_dout  = req_dout_q;
    assign dbg_state     = state_q;
endmodule

// File: tb/tb_sdram_rr_arbiter.sv
// Scoreboard bench for sdram_rr_arbiter: directed requests, a latency-programmable controller
// model, and monitors on both the controller side and the requester ready/dout side.
module tb_sdram_rr_arbiter;
    localparam int NP = 4;
    localparam int AW = 25;

    logic clk = 1'b0;
    logic resetn;
    logic [1:0] dbg_state;

    sdram_rr_arbiter_if #(.NPORTS(NP), .AW(AW)) bus ();

    sdram_rr_arbiter #(.NPORTS(NP), .AW(AW)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    // Scoreboard queues: requester-side {onehot, dout}, controller-side {addr, din, wmask},
    // and the model's responses {latency, dout}.
    logic [35:0] exp_q[$];
    logic [60:0] exp_mem_q[$];
    logic [39:0] rsp_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int hold_cnt[NP];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Every driver step goes through tick so requesters drop valid on their ready pulse.
    task automatic tick();
        @(negedge clk);
        for (int i = 0; i < NP; i++) begin
            if (bus.req_ready[i]) begin
                if (hold_cnt[i] > 0) hold_cnt[i]--;
                else bus.req_valid[i] = 1'b0;
            end
        end
    endtask

    task automatic drive_req(input int port, input logic [AW-1:0] addr,
                             input logic [31:0] din, input logic [3:0] wmask);
        bus.req_addr[port*AW +: AW] = addr;
        bus.req_din[port*32 +: 32]  = din;
        bus.req_wmask[port*4 +: 4]  = wmask;
        bus.req_valid[port]         = 1'b1;
    endtask

    task automatic expect_txn(input int port, input logic [AW-1:0] addr, input logic [31:0] din,
                              input logic [3:0] wmask, input int lat, input logic [31:0] rdata,
                              input bit exp_ready);
        exp_mem_q.push_back({addr, din, wmask});
        rsp_q.push_back({8'(lat), rdata});
        if (exp_ready) exp_q.push_back({4'(1 << port), rdata});
    endtask

    task automatic wait_done(input string name, input int budget);
        bit done = 1'b0;
        for (int c = 0; c < budget; c++) begin
            if (exp_q.size() == 0 && exp_mem_q.size() == 0 && rsp_q.size() == 0 &&
                bus.req_valid == '0 && dbg_state == 2'd0) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        if (!done) check({name, "_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic do_reset(input string name);
        resetn        = 1'b0;
        bus.req_valid = '0;
        for (int i = 0; i < NP; i++) hold_cnt[i] = 0;
        tick();
        tick();
        check({name, "_mem_valid"}, bus.mem_valid, 64'd0);
        check({name, "_req_ready"}, bus.req_ready, 64'd0);
        check({name, "_req_dout"},  bus.req_dout,  64'd0);
        check({name, "_state"},     dbg_state,     64'd0);
        resetn = 1'b1;
        tick();
    endtask

    // Controller model: checks the forwarded request, then answers after the queued latency.
    initial begin
        logic [60:0] m;
        logic [39:0] r;
        bit aborted;
        bus.mem_ready = 1'b0;
        bus.mem_dout  = '0;
        forever begin
            @(negedge clk);
            if (resetn && bus.mem_valid) begin
                m = '0;
                r = {8'd1, 32'h0};
                if (exp_mem_q.size() == 0) check("mem_unexpected_valid", 64'd1, 64'd0);
                else begin
                    m = exp_mem_q.pop_front();
                    check("mem_addr",  bus.mem_addr,  m[60:36]);
                    check("mem_din",   bus.mem_din,   m[35:4]);
                    check("mem_wmask", bus.mem_wmask, m[3:0]);
                end
                if (rsp_q.size() != 0) r = rsp_q.pop_front();
                aborted = 1'b0;
                for (int c = 1; c < int'(r[39:32]); c++) begin
                    @(negedge clk);
                    if (!resetn) begin
                        aborted = 1'b1;
                        break;
                    end
                end
                if (!aborted) begin
                    check("mem_addr_held", bus.mem_addr, m[60:36]);
                    bus.mem_ready = 1'b1;
                    bus.mem_dout  = r[31:0];
                    @(negedge clk);
                    bus.mem_ready = 1'b0;
                    bus.mem_dout  = '0;
                    check("mem_valid_drop", bus.mem_valid, 64'd0);
                end
            end
        end
    end

    // Requester-side monitor: every ready pulse must match the next expected completion.
    initial begin
        logic [35:0] e;
        logic [NP-1:0] prev_ready = '0;
        forever begin
            @(negedge clk);
            if (resetn && bus.req_ready != '0) begin
                check("ready_pulse_width", prev_ready, 64'd0);
                if (exp_q.size() == 0) check("ready_unexpected", bus.req_ready, 64'd0);
                else begin
                    e = exp_q.pop_front();
                    check("ready_port", bus.req_ready, e[35:32]);
                    check("ready_dout", bus.req_dout,  e[31:0]);
                end
            end
            prev_ready = bus.req_ready;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn        = 1'b0;
        bus.req_valid = '0;
        bus.req_addr  = '0;
        bus.req_din   = '0;
        bus.req_wmask = '0;
        for (int i = 0; i < NP; i++) hold_cnt[i] = 0;

        do_reset("reset");

        // single read on port 2, grant one cycle after valid
        expect_txn(2, 25'h0012340, 32'h0, 4'h0, 10, 32'hDEADBEEF, 1'b1);
        drive_req(2, 25'h0012340, 32'h0, 4'h0);
        tick();
        check("grant_latency", bus.mem_valid, 64'd1);
        wait_done("read", 100);

        // write pass-through on port 1; read data is still returned
        expect_txn(1, 25'h1000004, 32'hA5A55A5A, 4'b0011, 4, 32'h00001111, 1'b1);
        drive_req(1, 25'h1000004, 32'hA5A55A5A, 4'b0011);
        wait_done("write", 100);

        do_reset("reset2");
`ifdef SDRAM_ARB_FIXED_PRIO_EN
        // ports 0 and 3 held: port 0 wins three times, then port 3
        hold_cnt[0] = 2;
        expect_txn(0, 25'h0000100, 32'h0, 4'h0, 3, 32'h0000A000, 1'b1);
        expect_txn(0, 25'h0000100, 32'h0, 4'h0, 3, 32'h0000A001, 1'b1);
        expect_txn(0, 25'h0000100, 32'h0, 4'h0, 3, 32'h0000A002, 1'b1);
        expect_txn(3, 25'h0000300, 32'h0, 4'h0, 3, 32'h0000A003, 1'b1);
        drive_req(0, 25'h0000100, 32'h0, 4'h0);
        drive_req(3, 25'h0000300, 32'h0, 4'h0);
        wait_done("fixed_prio", 200);
`else
        // all four ports contend; port 0 asks twice -> 0,1,2,3,0
        hold_cnt[0] = 1;
        expect_txn(0, 25'h0000100, 32'h00000000, 4'h0, 3, 32'hC0000000, 1'b1);
        expect_txn(1, 25'h0000200, 32'h11111111, 4'hF, 5, 32'hC1111111, 1'b1);
        expect_txn(2, 25'h0000300, 32'h00000000, 4'h0, 2, 32'hC2222222, 1'b1);
        expect_txn(3, 25'h0000400, 32'h33333333, 4'h8, 4, 32'hC3333333, 1'b1);
        expect_txn(0, 25'h0000100, 32'h00000000, 4'h0, 3, 32'hC0000001, 1'b1);
        drive_req(0, 25'h0000100, 32'h00000000, 4'h0);
        drive_req(1, 25'h0000200, 32'h11111111, 4'hF);
        drive_req(2, 25'h0000300, 32'h00000000, 4'h0);
        drive_req(3, 25'h0000400, 32'h33333333, 4'h8);
        wait_done("contention", 300);
`endif

        // ports 1 and 3 together: 1 is served first in both modes
        expect_txn(1, 25'h1FFFFFF, 32'h0, 4'h0, 2, 32'h12345678, 1'b1);
        expect_txn(3, 25'h0ABCDEF, 32'hFFFFFFFF, 4'b1111, 6, 32'h87654321, 1'b1);
        drive_req(1, 25'h1FFFFFF, 32'h0, 4'h0);
        drive_req(3, 25'h0ABCDEF, 32'hFFFFFFFF, 4'b1111);
        wait_done("pair", 200);

        // abort: reset while BUSY gives no ready; a later port 1 request completes
        expect_txn(3, 25'h0000ABC, 32'h0, 4'h0, 40, 32'hBADBAD00, 1'b0);
        drive_req(3, 25'h0000ABC, 32'h0, 4'h0);
        for (int c = 0; c < 5; c++) tick();
        check("abort_busy", dbg_state, 64'd1);
        do_reset("abort_reset");
        for (int c = 0; c < 50; c++) tick();
        expect_txn(1, 25'h0000777, 32'h0, 4'h0, 3, 32'h0F0F0F0F, 1'b1);
        drive_req(1, 25'h0000777, 32'h0, 4'h0);
        wait_done("after_abort", 100);

        check("queues_empty", exp_q.size() + exp_mem_q.size() + rsp_q.size(), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
